// File: rtl/ring_measure_pkg.sv
// Shared types and constants for the ring-oscillator measurement counter.
package ring_measure_pkg;

    localparam int unsigned DEF_GATE_W = 16;
    localparam int unsigned DEF_CNT_W  = 32;
    localparam int unsigned ARM_CYCLES = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARM   = 2'd1,
        COUNT = 2'd2,
        HOLD  = 2'd3
    } ring_state_t;

    typedef enum logic {
        EDGE_RISE = 1'b0,
        EDGE_BOTH = 1'b1
    } edge_mode_t;

endpackage

// File: rtl/sync_edge_detect.sv
// Two-flop synchroniser for an asynchronous level plus an edge-detect flop.
// Edge mode selects rising-only or both-edge pulses.
module sync_edge_detect
    import ring_measure_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_async,
    input  edge_mode_t i_edge_mode,
    output logic       o_edge_c
);

    logic r_sync1;
    logic r_sync2;
    logic r_prev;
    logic w_rise;
    logic w_any;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_prev  <= 1'b0;
        end else begin
            r_sync1 <= i_async;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
        end
    end

    assign w_rise   = r_sync2 & ~r_prev;
    assign w_any    = r_sync2 ^ r_prev;
    assign o_edge_c = (i_edge_mode == EDGE_BOTH) ? w_any : w_rise;

endmodule

// File: rtl/ring_measure_counter.sv
// Counts synchronised ring-oscillator edges over a programmable clock window
// and offers the saturating count on a valid/ready port.
// Define RING_COUNT_BOTH_EDGES_EN to count both edges instead of rising only.
module ring_measure_counter
    import ring_measure_pkg::*;
#(
    parameter int unsigned GATE_W = DEF_GATE_W,
    parameter int unsigned CNT_W  = DEF_CNT_W
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_n,
    input  logic              ring_in,
    input  logic              start,
    input  logic [GATE_W-1:0] gate_cycles,
    output logic              busy,
    output logic [CNT_W-1:0]  result,
    output logic              result_valid,
    input  logic              result_ready,
    output logic              overflow
);

    localparam int unsigned       ARM_CNT_W = 2;
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

`ifdef RING_COUNT_BOTH_EDGES_EN
    localparam edge_mode_t EDGE_MODE = EDGE_BOTH;
`else
    localparam edge_mode_t EDGE_MODE = EDGE_RISE;
`endif

    ring_state_t          r_state;
    logic [ARM_CNT_W-1:0] r_arm_cnt;
    logic [GATE_W-1:0]    r_win;
    logic [CNT_W-1:0]     r_count;
    logic                 r_busy;
    logic                 r_valid;
    logic                 r_overflow;
    logic                 w_edge;
    logic                 w_sat;

    sync_edge_detect u_sync (
        .i_clk       (wb_clk_i),
        .i_rst_n     (wb_rst_n),
        .i_async     (ring_in),
        .i_edge_mode (EDGE_MODE),
        .o_edge_c    (w_edge)
    );

    assign w_sat = (r_count == CNT_MAX);

    // Control FSM; busy/valid are updated alongside each state change.
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_n) begin
            r_state    <= IDLE;
            r_arm_cnt  <= '0;
            r_win      <= '0;
            r_count    <= '0;
            r_busy     <= 1'b0;
            r_valid    <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_state    <= ARM;
                        r_busy     <= 1'b1;
                        r_arm_cnt  <= '0;
                        r_win      <= gate_cycles;
                        r_count    <= '0;
                        r_overflow <= 1'b0;
                    end
                end
                ARM: begin
                    r_arm_cnt <= r_arm_cnt + ARM_CNT_W'(1);
                    if (r_arm_cnt == ARM_CNT_W'(ARM_CYCLES - 1)) begin
                        if (r_win == '0) begin
                            r_state <= HOLD;
                            r_busy  <= 1'b0;
                            r_valid <= 1'b1;
                        end else begin
                            r_state <= COUNT;
                        end
                    end
                end
                COUNT: begin
                    // An edge arriving at saturation only flags overflow.
                    if (w_edge) begin
                        if (w_sat) begin
                            r_overflow <= 1'b1;
                        end else begin
                            r_count <= r_count + CNT_W'(1);
                        end
                    end
                    r_win <= r_win - GATE_W'(1);
                    if (r_win == GATE_W'(1)) begin
                        r_state <= HOLD;
                        r_busy  <= 1'b0;
                        r_valid <= 1'b1;
                    end
                end
                HOLD: begin
                    if (result_ready) begin
                        r_state <= IDLE;
                        r_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

    assign busy         = r_busy;
    assign result       = r_count;
    assign result_valid = r_valid;
    assign overflow     = r_overflow;

endmodule

// File: doc/ring_measure_counter.md
# ring_measure_counter

Downstream measurement stage for the instrumented ripple adder. It takes the adder's asynchronous chain output, which runs as a ring oscillator when the adder is in loop mode, and synchronises it into the `wb_clk_i` domain. It counts the oscillator's edges over a programmable window of clock cycles and presents the saturating count through a valid/ready result port that the wrapper exposes on the logic-analyser bus.

## Interface
Parameters:
- `GATE_W`, 16: width of the gate-window length.
- `CNT_W`, 32: width of the edge counter and result.

Ports:
- `wb_clk_i`  in  1  sole clock.
- `wb_rst_n`  in  1  reset; synchronous, active-low.
- `ring_in`  in  1  asynchronous adder chain output (oscillator).
- `start`  in  1  request a measurement; sampled only in IDLE.
- `gate_cycles`  in  GATE_W  window length in clock cycles; latched when `start` is accepted.
- `busy`  out  1  high in ARM and COUNT.
- `result`  out  CNT_W  edge count; stable while `result_valid` is high.
- `result_valid`  out  1  result available.
- `result_ready`  in  1  consumer accepts the result.
- `overflow`  out  1  count saturated during the last measurement.

## Operation
- Front end:
  - Two-flop synchroniser on `ring_in`, then a third flop for edge detect.
  - An edge pulse means a rising edge of the synchronised signal, or either edge when `RING_COUNT_BOTH_EDGES_EN` is defined.
- FSM states: IDLE, ARM, COUNT, HOLD.
  - IDLE -> ARM when `start`=1. Latch `gate_cycles` into the window down-counter, clear the count, and clear `overflow`.
  - ARM lasts exactly 2 cycles so the synchroniser can flush. Edge pulses during ARM are discarded.
  - ARM -> COUNT when the latched gate is nonzero. ARM -> HOLD directly when the latched gate is 0; `result` is then 0.
  - COUNT lasts exactly the latched gate value in cycles. Each edge pulse increments the count. An edge in the final COUNT cycle is included. COUNT -> HOLD after the last cycle.
  - HOLD: `result_valid`=1. HOLD -> IDLE on the cycle where `result_valid` and `result_ready` are both high.
- `start` outside IDLE is ignored; it is not queued. This includes `start` in the same cycle as a HOLD handshake.
- Arithmetic: the count saturates at 2^CNT_W−1. Any edge pulse at saturation sets `overflow`, which stays high until the next accepted `start`.
- `result` is driven from the count register, which is frozen in HOLD and IDLE. `result` is therefore stable from HOLD until the next `start`.
- `gate_cycles` changes after acceptance have no effect on the current measurement.

## Timing
- Reset values: state IDLE; `busy`=0, `result`=0, `result_valid`=0, `overflow`=0; synchroniser flops 0.
- Reset asserted mid-operation returns the block to the reset state on the next edge. Any partial count is discarded.
- Cycle numbering for `start` accepted at cycle 0:
  - ARM = cycles 1–2.
  - COUNT = cycles 3 .. 2+G.
  - `result_valid` rises at cycle 3+G.
  - Gate 0 gives `result_valid` at cycle 3.
- `busy` is registered with the state: high in cycles 1 .. 2+G.
- Input-to-count latency from a `ring_in` edge is 3 cycles. Rising-edge mode counts at most one edge per 2 clocks; both-edge mode counts at most one per clock.

## Configuration
- `RING_COUNT_BOTH_EDGES_EN` defined: edge pulse on either transition of the synchronised signal. The count is twice the oscillation cycles.
- Not defined: rising edges only.

## Structure
- Package `ring_measure_pkg` holds:
  - the state enum `ring_state_t` {IDLE, ARM, COUNT, HOLD};
  - the constant `ARM_CYCLES`=2;
  - the default `GATE_W` and `CNT_W`.
- Sub-module `sync_edge_detect`: 2-flop synchroniser plus edge flop, with an edge-mode input driven by the macro. It is instantiated once.

## Test plan
- `ring_in` toggling every 4 clocks, G=64, rising mode -> `result`=8, `overflow`=0, `result_valid` at cycle 67.
- Same stimulus with `RING_COUNT_BOTH_EDGES_EN` -> `result`=16.
- CNT_W=8, `ring_in` toggling every clock, G=1000 -> `result`=255, `overflow`=1.
- G=0 -> `result_valid` at cycle 3 with `result`=0. Hold `result_ready` low 10 cycles while pulsing `start` -> `result` unchanged, `start` ignored, IDLE one cycle after the ready handshake.
- `wb_rst_n` low for 1 cycle at cycle 20 of a G=100 run -> all outputs 0 the following cycle. A new `start` then yields a correct fresh count.
- Change `gate_cycles` from 10 to 50 during COUNT -> window still 10 cycles, `result_valid` at cycle 13.
